control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
// - Multicycle control FSM for the 32-bit accumulator RISC datapath.
// - Takes the 4-bit opcode from the instruction register and sequences FETCH -> DECODE -> EXEC.
// - Drives the PC, IR, ACC, memory and address-mux control strobes.
// - Sits between the IR/ACC-zero flag and the datapath/memory enables.
// PARAMETERS
// - none (opcode width fixed at 4; state encoding is implementation choice)
// PORTS
// - clk      in   1  rising-edge clock (single clock domain)
// - reset    in   1  asynchronous, active-high reset
// - opcode   in   4  IR[31:28]; sampled combinationally in EXEC
// - acc_zero in   1  1 when ACC == 0 (used by JZ)
// - incpc    out  1  PC <= PC + 1
// - ldacc    out  1  load ACC from ALU/memory result
// - ldir     out  1  load IR from memory data bus
// - ldpc     out  1  load PC from IR operand field
// - rd       out  1  memory read strobe
// - rst      out  1  synchronous clear of ACC (datapath-level clear)
// - wr       out  1  memory write strobe (ACC -> mem)
// - y        out  1  address mux select: 1 = IR operand address, 0 = PC
// - halted   out  1  1 while in HALT state
// BEHAVIOUR
// - States: INIT, FETCH, DECODE, EXEC, HALT.
// - All outputs are combinational from (state, opcode, acc_zero); no output registers.
// - reset=1 forces INIT immediately. In INIT: rst=1, all other outputs 0.
// - INIT -> FETCH on the first clk after reset deasserts.
// - FETCH: rd=1, ldir=1, incpc=1, y=0; others 0. FETCH -> DECODE.
// - DECODE: all outputs 0. DECODE -> EXEC.
// - EXEC: outputs per opcode table below. EXEC -> FETCH, except HLT -> HALT.
// - EXEC opcode table (unlisted strobes are 0):
//     0000 NOP  : none
//     0001 LDA  : y, rd, ldacc
//     0010-0110 ADD/SUB/AND/OR/XOR : y, rd, ldacc
//     0111 NOT, 1000 SHL, 1001 SHR : ldacc
//     1010 CLR  : rst
//     1011 SKIP : incpc
//     1100 JMP  : ldpc
//     1101 JZ   : ldpc only if acc_zero=1, else none
//     1110 STA  : y, wr (rd=0)
//     1111 HLT  : none; next state HALT
// - HALT: all outputs 0, halted=1. Stays in HALT until reset.
// - Invariants:
//   - rd and wr are never both 1.
//   - ldpc and incpc are never both 1.
//   - Exactly 3 cycles per instruction (FETCH, DECODE, EXEC).
// - Opcode changes in FETCH/DECODE have no effect on outputs or transitions.
// - Reset asserted mid-instruction aborts it: INIT immediately, strobes drop to 0 except rst.
// - X/Z on opcode in EXEC: all strobes 0; treated as NOP.
// CONFIGURATION
// - CU_HALT_EN defined:
//   - 1111 = HLT as specified; halted asserts in HALT.
// - CU_HALT_EN undefined:
//   - 1111 decodes as NOP; EXEC -> FETCH.
//   - HALT state unreachable; halted tied to 0.
// TESTING
// - Reset: hold reset=1 -> rst=1, all else 0. Release -> next edge FETCH: rd=1, ldir=1, incpc=1, y=0.
// - opcode=1011 in EXEC -> incpc=1, ldpc=0, rd=0, wr=0; next state FETCH.
// - opcode=1110 in EXEC -> y=1, wr=1, rd=0, ldacc=0.
// - opcode=1101, acc_zero=1 -> ldpc=1. Repeat with acc_zero=0 -> ldpc=0.
// - opcode=0001 in EXEC -> y=1, rd=1, ldacc=1. Change opcode during DECODE -> DECODE outputs stay 0.
// - CU_HALT_EN on: opcode=1111 -> HALT, halted=1, strobes 0 for 10 cycles; reset returns to INIT.
//   - CU_HALT_EN off: 1111 behaves as NOP.

Source files
------------

// File: rtl/control_unit.sv
// Multicycle FETCH/DECODE/EXEC control FSM for the accumulator RISC datapath.
// Define CU_HALT_EN to make opcode 1111 a HLT that parks the FSM in HALT.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  output logic       incpc,
  output logic       ldacc,
  output logic       ldir,
  output logic       ldpc,
  output logic       rd,
  output logic       rst,
  output logic       wr,
  output logic       y,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
`ifdef CU_HALT_EN
        if (opcode === 4'b1111) state_d = S_HALT;
`endif
      end
`ifdef CU_HALT_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_INIT;
    endcase
  end

  // Outputs are decoded straight from state; an unknown opcode falls to default.
  always_comb begin
    incpc  = 1'b0;
    ldacc  = 1'b0;
    ldir   = 1'b0;
    ldpc   = 1'b0;
    rd     = 1'b0;
    rst    = 1'b0;
    wr     = 1'b0;
    y      = 1'b0;
    halted = 1'b0;
    case (state_q)
      S_INIT: rst = 1'b1;
      S_FETCH: begin
        rd    = 1'b1;
        ldir  = 1'b1;
        incpc = 1'b1;
      end
      S_EXEC: begin
        case (opcode)
          4'b0001, 4'b0010, 4'b0011,
          4'b0100, 4'b0101, 4'b0110: begin
            y     = 1'b1;
            rd    = 1'b1;
            ldacc = 1'b1;
          end
          4'b0111, 4'b1000, 4'b1001: ldacc = 1'b1;
          4'b1010: rst   = 1'b1;
          4'b1011: incpc = 1'b1;
          4'b1100: ldpc  = 1'b1;
          4'b1101: ldpc  = acc_zero;
          4'b1110: begin
            y  = 1'b1;
            wr = 1'b1;
          end
          default: ;
        endcase
      end
`ifdef CU_HALT_EN
      S_HALT: halted = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit; expected strobe vectors are
// queued per instruction and popped one per cycle mid-cycle.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       acc_zero;
  logic       incpc, ldacc, ldir, ldpc, rd, rst, wr, y, halted;

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_q[$];

  localparam logic [8:0] V_INIT  = 9'b000001000;
  localparam logic [8:0] V_FETCH = 9'b101010000;
  localparam logic [8:0] V_ZERO  = 9'b000000000;
  localparam logic [8:0] V_HALT  = 9'b000000001;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .acc_zero(acc_zero),
    .incpc(incpc), .ldacc(ldacc), .ldir(ldir), .ldpc(ldpc),
    .rd(rd), .rst(rst), .wr(wr), .y(y), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {incpc, ldacc, ldir, ldpc, rd, rst, wr, y, halted};
  endfunction

  // Reference decode of the EXEC opcode table.
  function automatic logic [8:0] exec_exp(logic [3:0] op, logic az);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: return 9'b010010010;
      4'h7, 4'h8, 4'h9: return 9'b010000000;
      4'hA: return 9'b000001000;
      4'hB: return 9'b100000000;
      4'hC: return 9'b000100000;
      4'hD: return az ? 9'b000100000 : 9'b000000000;
      4'hE: return 9'b000000110;
      default: return 9'b000000000;
    endcase
  endfunction

  task automatic check(input string tag);
    logic [8:0] got, e;
    got = outs();
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: scoreboard empty, observed %b", tag, got);
      return;
    end
    e = exp_q.pop_front();
    tests++;
    assert (got === e) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, e);
    end
    tests++;
    assert (!(rd && wr) && !(ldpc && incpc)) else begin
      fails++;
      $error("FAIL %s_inv: observed rd=%b wr=%b ldpc=%b incpc=%b expected no overlap",
             tag, rd, wr, ldpc, incpc);
    end
  endtask

  task automatic instr(input logic [3:0] op, input logic az, input string tag);
    exp_q.push_back(V_FETCH);
    exp_q.push_back(V_ZERO);
    exp_q.push_back(exec_exp(op, az));
    @(negedge clk);
    opcode = ~op; acc_zero = ~az;
    #1 check({tag, "_fetch"});
    @(negedge clk);
    opcode = op ^ 4'b0101;
    #1 check({tag, "_decode"});
    @(negedge clk);
    opcode = op; acc_zero = az;
    #1 check({tag, "_exec"});
  endtask

  initial begin
    reset = 1'b1; opcode = 4'h0; acc_zero = 1'b0;
    repeat (2) begin
      @(negedge clk);
      exp_q.push_back(V_INIT);
      #1 check("reset_hold");
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(V_INIT);
    #1 check("reset_release");

    instr(4'h0, 1'b0, "nop");
    instr(4'hB, 1'b0, "skip");
    instr(4'hE, 1'b0, "sta");
    instr(4'hD, 1'b1, "jz_taken");
    instr(4'hD, 1'b0, "jz_not");
    instr(4'h1, 1'b0, "lda");
    instr(4'h3, 1'b1, "sub");
    instr(4'h8, 1'b0, "shl");
    instr(4'hA, 1'b0, "clr");
    instr(4'hC, 1'b1, "jmp");

    // Abort an instruction in DECODE with an asynchronous reset.
    exp_q.push_back(V_FETCH);
    exp_q.push_back(V_ZERO);
    exp_q.push_back(V_INIT);
    exp_q.push_back(V_INIT);
    @(negedge clk);
    opcode = 4'h1;
    #1 check("abort_fetch");
    @(negedge clk);
    #1 check("abort_decode");
    #1 reset = 1'b1;
    #1 check("abort_init");
    @(negedge clk);
    reset = 1'b0;
    #1 check("abort_release");

    instr(4'h6, 1'b0, "xor_after_abort");

`ifdef CU_HALT_EN
    instr(4'hF, 1'b0, "hlt");
    repeat (10) begin
      @(negedge clk);
      opcode = $urandom_range(15, 0);
      exp_q.push_back(V_HALT);
      #1 check("halt_hold");
    end
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(V_INIT);
    #1 check("halt_reset");
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(V_INIT);
    #1 check("halt_release");
    instr(4'h1, 1'b0, "lda_after_halt");
`else
    instr(4'hF, 1'b0, "hlt_as_nop");
    instr(4'hB, 1'b0, "skip_after_f");
`endif

    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL queue_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
